// File: rtl/marcador_pkg.sv
// Shared constants for the score keeper: game state codes, win/lose codes,
// conversion FSM encoding and seven-segment glyphs.
package marcador_pkg;

  // Game FSM state codes driven on presente
  localparam logic [2:0] PRES_MENU      = 3'd0;
  localparam logic [2:0] PRES_SELECCION = 3'd1;
  localparam logic [2:0] PRES_JUEGO     = 3'd2;
  localparam logic [2:0] PRES_FIN       = 3'd3;

  // W_or_L codes
  localparam logic [1:0] WL_JUGANDO = 2'b00;
  localparam logic [1:0] WL_GANA    = 2'b01;
  localparam logic [1:0] WL_PIERDE  = 2'b10;

  // Conversion FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  // Widths of the binary score and its BCD image
  localparam int BIN_W  = 10;
  localparam int BCD_W  = 12;
  localparam int ITERS  = 10;

  // Glyphs, bit order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Nibble to glyph; a non-decimal nibble blanks the digit
  function automatic logic [6:0] bcd_a_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/marcador_bcd_bin2bcd_seq.sv
// Sequential double-dabble: one adjust+shift iteration per clock.
// Handshake: start is accepted while !busy; busy stays high for the
// ITERS iterations; done is high during the final iteration cycle, so bcd
// holds the result from the following cycle until the next start.
module bin2bcd_seq
  import marcador_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  // {bcd field, binary field} shifted together
  logic [BCD_W+BIN_W-1:0] sr;
  logic [BCD_W+BIN_W-1:0] sr_adj;
  logic [3:0]             iter;

  // Add 3 to every BCD nibble that is 5 or more before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then iterate until the last bit has been shifted in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      iter <= 4'd0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      sr   <= {{BCD_W{1'b0}}, bin};
      iter <= 4'd0;
      busy <= 1'b1;
    end else if (busy) begin
      sr   <= {sr_adj[BCD_W+BIN_W-2:0], 1'b0};
      iter <= iter + 4'd1;
      if (iter == 4'(ITERS - 1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (iter == 4'(ITERS - 1));
  assign bcd  = sr[BCD_W+BIN_W-1:BIN_W];

endmodule

// File: rtl/marcador_bcd.sv
// Score keeper: accumulates bonus and win points during play, keeps the
// session high score, and refreshes a three-digit seven-segment image of
// the score through a sequential binary-to-BCD conversion.
module marcador_bcd
  import marcador_pkg::*;
#(
  parameter logic [9:0] BONO_PTS = 10'd5,
  parameter logic [9:0] WIN_PTS  = 10'd50,
  parameter logic [9:0] MAX_PTS  = 10'd999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  presente,
  input  logic [1:0]  W_or_L,
  input  logic        bono_tomado,
  output logic [20:0] display_puntaje,
  output logic [9:0]  puntaje,
  output logic [9:0]  record,
  output logic        nuevo_record,
  output logic        busy
);

  logic        bono_s1, bono_s2, bono_s2_q;
  logic        bono_evt, win_evt;
  logic [1:0]  wl_q;
  logic [2:0]  pres_q;
  logic        entra_sel, entra_fin;
  logic [10:0] suma;
  logic [9:0]  puntaje_sig;

  // Conversion path
  logic [1:0]       estado;
  logic             pendiente;
  logic [9:0]       puntaje_q;
  logic             cambio;
  logic             conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0] conv_bcd;

  // Bonus input crosses domains: two-flop synchronizer plus edge-detect flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bono_s1   <= 1'b0;
      bono_s2   <= 1'b0;
      bono_s2_q <= 1'b0;
    end else begin
      bono_s1   <= bono_tomado;
      bono_s2   <= bono_s1;
      bono_s2_q <= bono_s2;
    end
  end

  // Previous W_or_L and presente for edge/entry detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wl_q   <= WL_JUGANDO;
      pres_q <= PRES_MENU;
    end else begin
      wl_q   <= W_or_L;
      pres_q <= presente;
    end
  end

  assign bono_evt  = bono_s2 & ~bono_s2_q;
  assign win_evt   = (W_or_L == WL_GANA) && (wl_q != WL_GANA);
  assign entra_sel = (presente == PRES_SELECCION) && (pres_q != PRES_SELECCION);
  assign entra_fin = (presente == PRES_FIN) && (pres_q != PRES_FIN);

  // Next score in 11 bits so the saturation compare sees any overflow
  always_comb begin
    suma = {1'b0, puntaje}
         + (bono_evt ? {1'b0, BONO_PTS} : 11'd0)
         + (win_evt  ? {1'b0, WIN_PTS}  : 11'd0);
    puntaje_sig = (suma > {1'b0, MAX_PTS}) ? MAX_PTS : suma[9:0];
  end

  // Score: cleared on entry to selection, accumulates only during play
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puntaje <= 10'd0;
    end else if (entra_sel) begin
      puntaje <= 10'd0;
    end else if (presente == PRES_JUEGO) begin
      puntaje <= puntaje_sig;
    end
  end

  // High score captured on entry to the end screen; flag lives while there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      record       <= 10'd0;
      nuevo_record <= 1'b0;
    end else if (entra_fin) begin
      if (puntaje > record) begin
        record       <= puntaje;
        nuevo_record <= 1'b1;
      end
    end else if (presente != PRES_FIN) begin
      nuevo_record <= 1'b0;
    end
  end

  assign cambio     = (puntaje != puntaje_q);
  assign conv_start = (estado == ST_IDLE) && (cambio || pendiente) && !conv_busy;

  // Remember the last score seen to detect changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puntaje_q <= 10'd0;
    end else begin
      puntaje_q <= puntaje;
    end
  end

  // One pending refresh is enough: the restart always latches the newest score
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendiente <= 1'b0;
    end else if (conv_start) begin
      pendiente <= 1'b0;
    end else if (cambio) begin
      pendiente <= 1'b1;
    end
  end

  // Conversion sequencer: IDLE -> SHIFT (core iterating) -> LOAD (register glyphs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= ST_IDLE;
      display_puntaje <= {SEG_0, SEG_0, SEG_0};
    end else begin
      case (estado)
        ST_IDLE: begin
          if (conv_start) estado <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (conv_done) estado <= ST_LOAD;
        end
        ST_LOAD: begin
          display_puntaje <= {bcd_a_seg(conv_bcd[11:8]),
                              bcd_a_seg(conv_bcd[7:4]),
                              bcd_a_seg(conv_bcd[3:0])};
          estado          <= ST_IDLE;
        end
        default: estado <= ST_IDLE;
      endcase
    end
  end

  assign busy = (estado != ST_IDLE);

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (puntaje),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

endmodule
